// File: rtl/systolic_result_drain.sv
// -----------------------------------------------------------------------------
// systolic_result_drain
//
// Sits behind systolic_array. On each rising edge of compute_done it copies the
// whole accumulator matrix into a local snapshot. The array is then free to
// start its next run. The snapshot is streamed out one row per beat. Each
// element is arithmetically shifted right by SHIFT and saturated to OUT_WIDTH
// signed bits.
//
// Handshake (valid/ready):
//   A beat transfers on a rising clk edge where out_valid & out_ready is 1.
//   Once out_valid rises it stays high until that beat transfers.
//   out_data, out_row and out_last are held stable while out_valid & ~out_ready.
//   out_valid never depends on out_ready in the same cycle.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   compute_done    level from the array; its rising edge triggers a capture
//   acc_matrix      element (i,j) at [(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH], signed
//   out_valid       a beat is available
//   out_ready       the sink accepts the beat
//   out_data        lane j at [j*OUT_WIDTH +: OUT_WIDTH], signed and saturated
//   out_row         row index of the current beat
//   out_last        the current beat is row ROWS-1
//   busy            a snapshot is held and streaming; this is the FSM state view
//   sat_count       saturated elements in transferred beats; clamps at 0xFFFF
//   overrun         sticky; a capture trigger arrived while busy
// -----------------------------------------------------------------------------
module systolic_result_drain #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 0,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           compute_done,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_matrix,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [COLS*OUT_WIDTH-1:0]      out_data,
  output logic [ROW_W-1:0]               out_row,
  output logic                           out_last,
  output logic                           busy,
  output logic [15:0]                    sat_count,
  output logic                           overrun
);

  // The saturation bounds are sign-extended to the accumulator width.
  // Comparing at full width therefore needs no truncation first.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS-1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                      done_prev;
  logic                      trigger;
  logic                      xfer;
  logic                      last_row;
  logic [ROW_W-1:0]          row;
  logic [COLS*ACC_WIDTH-1:0] snap [ROWS];

  logic [COLS*OUT_WIDTH-1:0] lane_data;
  logic [15:0]               sat_lanes;
  logic [16:0]               sat_sum;
  logic signed [ACC_WIDTH-1:0] elem;
  logic signed [ACC_WIDTH-1:0] shifted;

  assign trigger  = compute_done & ~done_prev;
  assign xfer     = out_valid & out_ready;
  assign last_row = (row == LAST_ROW);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xfer && last_row) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Everything is gated by state, so IDLE is quiet (all zero).
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_last  = 1'b0;
    if (state == S_STREAM) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_data  = lane_data;
      out_row   = row;
      out_last  = last_row;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane rescale and saturate for the row currently on offer. The result
  // comes only from the snapshot and the row register, so it is stable during
  // a stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_data = '0;
    sat_lanes = '0;
    elem      = '0;
    shifted   = '0;
    for (int j = 0; j < COLS; j++) begin
      elem    = signed'(snap[row][j*ACC_WIDTH +: ACC_WIDTH]);
      shifted = elem >>> SHIFT;
      if (shifted > SAT_MAX) begin
        lane_data[j*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
        sat_lanes = sat_lanes + 16'd1;
      end else if (shifted < SAT_MIN) begin
        lane_data[j*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
        sat_lanes = sat_lanes + 16'd1;
      end else begin
        lane_data[j*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
      end
    end
  end

  // A 17-bit sum makes the clamp at 0xFFFF a simple carry test.
  assign sat_sum = {1'b0, sat_count} + {1'b0, sat_lanes};

  // ---------------------------------------------------------------------------
  // Datapath registers: edge detect, snapshot, row pointer and statistics.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
      row       <= '0;
      sat_count <= '0;
      overrun   <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        snap[r] <= '0;
      end
    end else begin
      done_prev <= compute_done;

      if (state == S_IDLE && trigger) begin
        for (int r = 0; r < ROWS; r++) begin
          snap[r] <= acc_matrix[r*COLS*ACC_WIDTH +: COLS*ACC_WIDTH];
        end
        row <= '0;
      end else if (xfer && !last_row) begin
        row <= row + 1'b1;
      end

      // A trigger while streaming is dropped. This includes the cycle of the
      // final transfer, because the state is still STREAM on that edge.
      if (state == S_STREAM && trigger) begin
        overrun <= 1'b1;
      end

      if (xfer) begin
        sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Downstream stage of `systolic_array`. On each rising edge of the array's `compute_done`, the block snapshots the flat accumulator bus `output_matrix`. It then rescales and saturates every element to a narrower signed width and streams the matrix out one row per beat over a valid/ready handshake. Because of the snapshot, the array can start its next run while the previous result is still draining.

## Interface
- `ROWS`, 8, array rows (≥1); one output beat per row
- `COLS`, 8, array columns (≥1); lanes per beat
- `ACC_WIDTH`, 48, signed accumulator width per element (matches array `OP_WIDTH`)
- `OUT_WIDTH`, 32, signed output element width; requires `OUT_WIDTH ≤ ACC_WIDTH - SHIFT`
- `SHIFT`, 0, arithmetic right shift applied before saturation (0..ACC_WIDTH-2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `compute_done`  in  1  level from the array; its rising edge triggers capture
- `acc_matrix`  in  ROWS*COLS*ACC_WIDTH  element (i,j) at bits `[(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH]`, signed
- `out_valid`  out  1  beat available
- `out_ready`  in  1  sink accepts the beat
- `out_data`  out  COLS*OUT_WIDTH  lane j at bits `[j*OUT_WIDTH +: OUT_WIDTH]`, signed
- `out_row`  out  max(1,$clog2(ROWS))  row index of the current beat
- `out_last`  out  1  current beat is row ROWS-1
- `busy`  out  1  snapshot held, stream in progress
- `sat_count`  out  16  count of saturated elements in transferred beats; sticks at 0xFFFF; cleared only by reset
- `overrun`  out  1  sticky; set when a capture trigger arrives while busy; cleared only by reset

## Operation
- Edge detect: `done_prev` is registered every cycle. Trigger = `compute_done & ~done_prev`. `done_prev` resets to 0.
- State machine has two states:
  - IDLE: outputs quiet. On a trigger, load the snapshot from `acc_matrix`, set row=0 and go to STREAM.
  - STREAM: `out_valid`=1.
    - Transfer = `out_valid & out_ready`.
    - On a transfer with row<ROWS-1: row++.
    - On a transfer with row=ROWS-1: go to IDLE.
- Trigger while in STREAM (including the cycle of the last transfer): set `overrun`=1. The snapshot is not reloaded and the trigger is dropped. Back-to-back results are dropped, never merged.
- Element arithmetic, per lane:
  - v = snapshot(row,j) >>> SHIFT (sign-preserving, floor).
  - If v > 2^(OUT_WIDTH-1)-1, output the max positive value and mark the element saturated.
  - If v < -2^(OUT_WIDTH-1), output the min negative value and mark the element saturated.
  - Otherwise output v[OUT_WIDTH-1:0].
- `sat_count` adds the number of saturated lanes in a beat only when that beat transfers, and clamps at 0xFFFF.
- `out_data`, `out_row` and `out_last` depend only on registered state (snapshot and row). They are stable while `out_valid & ~out_ready`.
- In IDLE, `out_data`=0, `out_row`=0 and `out_last`=0.
- `busy` equals (state==STREAM).

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, `busy`=0, `sat_count`=0, `overrun`=0. State is IDLE, the snapshot is cleared and `done_prev`=0.
- Reset mid-stream aborts immediately: the remaining rows are lost and all outputs take their reset values on the next cycle.
- Capture latency: if `compute_done` is first sampled high at edge N, then `out_valid`=1 and row 0 data appear after edge N, i.e. in the cycle following the sampling edge.
- Throughput: with `out_ready` held high, one row per cycle. A full drain takes ROWS cycles.
- `out_valid` drops in the cycle after the row ROWS-1 transfer.
- Earliest new capture: a trigger sampled one edge after the final transfer is accepted.
- `compute_done` held high indefinitely produces exactly one capture.
- `ROWS`=1: `out_last`=1 on the single beat.
- The sink may toggle `out_ready` arbitrarily. Stalls never drop, duplicate or reorder rows.

## Test plan
Unless noted, all scenarios use ROWS=2, COLS=2, ACC_WIDTH=48, OUT_WIDTH=16, SHIFT=0.

1. Basic drain.
   - Stimulus: acc = {(0,0)=5, (0,1)=-3, (1,0)=100, (1,1)=0}; pulse `compute_done`; `out_ready`=1.
   - Required: beats row0 = {5,-3}, then row1 = {100,0} with `out_last`=1, on consecutive cycles starting the cycle after the trigger. `sat_count`=0.
2. Saturation.
   - Stimulus: elements 40000 and -40000.
   - Required: outputs 32767 and -32768; `sat_count`=2 after transfer.
3. Shift.
   - Stimulus: SHIFT=4; elements 0x123 and -17.
   - Required: outputs 0x12 and -2.
4. Backpressure.
   - Stimulus: `out_ready` pattern 0,0,1,0,1.
   - Required: row0 held stable for 3 cycles, row1 transfers on the 5th cycle; `sat_count` unchanged while stalled.
5. Overrun.
   - Stimulus: second rising edge of `compute_done` while row0 is stalled.
   - Required: `overrun`=1; the original snapshot is streamed unchanged; no third beat.
6. Reset mid-stream.
   - Stimulus: assert `rst` after the row0 transfer.
   - Required: next cycle all outputs are 0. A new trigger after reset streams row0 first.
